tx_burst_scheduler: RTL and testbench

Burst-level controller in front of the GMSK transmit path. It arbitrates burst requests from up to NUM_REQ requesters and sequences the granted burst through the modulator front end: arm check, fire, payload symbol feed, tail symbols and inter-burst guard. It sits between the MAC-side requesters and the tx_burst block, and is the only driver of fire_burst and the modulator symbol input.

---
 rtl/tx_sched_pkg.sv | 24 ++
 rtl/tx_sched_arbiter.sv | 42 ++++
 rtl/tx_burst_scheduler.sv | 177 +++++++++++++++++
 tb/tb_tx_burst_scheduler.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/tx_sched_pkg.sv
// rtl/tx_sched_pkg.sv - shared state type, default parameters and index-width helper
package tx_sched_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ARM     = 3'd1,
    WAIT_IQ = 3'd2,
    PAYLOAD = 3'd3,
    TAIL    = 3'd4,
    GUARD   = 3'd5
  } state_t;

  localparam int DEF_NUM_REQ       = 2;
  localparam int DEF_LEN_BITS      = 8;
  localparam int DEF_TAIL_SYMBOLS  = 3;
  localparam int DEF_GUARD_SYMBOLS = 8;
  localparam int DEF_ARM_TIMEOUT   = 1023;

  // Never narrower than one bit, so a single requester still has an index.
  function automatic int clog2(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/tx_sched_arbiter.sv
// rtl/tx_sched_arbiter.sv - one-hot requester pick; round-robin from last owner when TX_SCHED_ROUND_ROBIN_EN
module tx_sched_arbiter
  import tx_sched_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ,
  parameter int IW      = clog2(NUM_REQ)
) (
  input  logic               enable,
  input  logic [NUM_REQ-1:0] req,
`ifdef TX_SCHED_ROUND_ROBIN_EN
  input  logic [IW-1:0]      last_owner,
`endif
  output logic [NUM_REQ-1:0] pick,
  output logic [IW-1:0]      pick_idx,
  output logic               any
);

  always_comb begin
    int          pos;
    logic [IW-1:0] idx;
    pick     = '0;
    pick_idx = '0;
    any      = 1'b0;
    pos      = 0;
    idx      = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
`ifdef TX_SCHED_ROUND_ROBIN_EN
      pos = int'(last_owner) + 1 + k;
      if (pos >= NUM_REQ) pos = pos - NUM_REQ;
`else
      pos = k;
`endif
      idx = IW'(pos);
      if (enable && !any && req[idx]) begin
        any       = 1'b1;
        pick[idx] = 1'b1;
        pick_idx  = idx;
      end
    end
  end

endmodule

// File: rtl/tx_burst_scheduler.sv
// rtl/tx_burst_scheduler.sv - burst arbiter/sequencer for the GMSK tx path; TX_SCHED_ROUND_ROBIN_EN selects round-robin
module tx_burst_scheduler
  import tx_sched_pkg::*;
#(
  parameter int NUM_REQ       = DEF_NUM_REQ,
  parameter int LEN_BITS      = DEF_LEN_BITS,
  parameter int TAIL_SYMBOLS  = DEF_TAIL_SYMBOLS,
  parameter int GUARD_SYMBOLS = DEF_GUARD_SYMBOLS,
  parameter int ARM_TIMEOUT   = DEF_ARM_TIMEOUT
) (
  input  logic                        clock,
  input  logic                        reset_n,
  input  logic [NUM_REQ-1:0]          req,
  input  logic [NUM_REQ*LEN_BITS-1:0] req_len,
  input  logic [NUM_REQ-1:0]          sym_data,
  output logic [NUM_REQ-1:0]          grant,
  output logic                        sym_ready,
  output logic [NUM_REQ-1:0]          done,
  output logic                        err,
  output logic                        busy,
  output logic                        fire_burst,
  input  logic                        is_armed,
  input  logic                        symbol_input_strobe,
  input  logic                        iq_valid,
  output logic                        tx_symbol
);

  localparam int IW      = clog2(NUM_REQ);
  localparam int LEN_MAX = (1 << LEN_BITS) - 1;
  localparam int MAX_A   = (LEN_MAX > TAIL_SYMBOLS) ? LEN_MAX : TAIL_SYMBOLS;
  localparam int MAX_B   = (GUARD_SYMBOLS > ARM_TIMEOUT) ? GUARD_SYMBOLS : ARM_TIMEOUT;
  localparam int CNT_MAX = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int CW      = $clog2(CNT_MAX + 1);

  localparam logic [CW-1:0] ONE        = CW'(1);
  localparam logic [CW-1:0] ARM_LAST   = CW'(ARM_TIMEOUT - 1);
  localparam logic [CW-1:0] TAIL_LAST  = CW'(TAIL_SYMBOLS - 1);
  localparam logic [CW-1:0] GUARD_LAST = CW'(GUARD_SYMBOLS - 1);

  state_t               state, state_next;
  logic [CW-1:0]        cnt;
  logic [IW-1:0]        owner;
  logic [LEN_BITS-1:0]  len_q, sel_len;
  logic                 strobe_q, sym_event, len_zero, arm_expired, iq_lost;
  logic [NUM_REQ-1:0]   pick;
  logic [IW-1:0]        pick_idx;
  logic                 pick_any;
`ifdef TX_SCHED_ROUND_ROBIN_EN
  logic [IW-1:0]        last_owner;
`endif

  // Only the strobe's rising edge counts; a strobe held for several clocks is one symbol.
  assign sym_event   = symbol_input_strobe & ~strobe_q;
  assign len_zero    = (len_q == '0);
  assign arm_expired = (cnt == ARM_LAST);
  assign iq_lost     = ~iq_valid;

  tx_sched_arbiter #(.NUM_REQ(NUM_REQ), .IW(IW)) u_arbiter (
    .enable     (state == IDLE),
    .req        (req),
`ifdef TX_SCHED_ROUND_ROBIN_EN
    .last_owner (last_owner),
`endif
    .pick       (pick),
    .pick_idx   (pick_idx),
    .any        (pick_any)
  );

  always_comb begin
    sel_len = '0;
    for (int i = 0; i < NUM_REQ; i++)
      if (pick[i]) sel_len = req_len[i*LEN_BITS +: LEN_BITS];
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (pick_any) state_next = ARM;
      ARM:     if (len_zero) state_next = IDLE;
               else if (is_armed) state_next = WAIT_IQ;
               else if (arm_expired) state_next = IDLE;
      WAIT_IQ: if (iq_valid) state_next = PAYLOAD;
      PAYLOAD: if (iq_lost) state_next = GUARD;
               else if (sym_event && cnt == ONE) state_next = TAIL;
      TAIL:    if (iq_lost) state_next = GUARD;
               else if (sym_event && cnt == TAIL_LAST) state_next = GUARD;
      GUARD:   if (sym_event && cnt == GUARD_LAST) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    fire_burst = (state == ARM) && !len_zero && is_armed;
    busy       = (state != IDLE);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      strobe_q   <= 1'b0;
      cnt        <= '0;
      owner      <= '0;
      len_q      <= '0;
      grant      <= '0;
      done       <= '0;
      err        <= 1'b0;
      sym_ready  <= 1'b0;
      tx_symbol  <= 1'b1;
`ifdef TX_SCHED_ROUND_ROBIN_EN
      last_owner <= IW'(NUM_REQ - 1);
`endif
    end else begin
      strobe_q  <= symbol_input_strobe;
      done      <= '0;
      err       <= 1'b0;
      sym_ready <= 1'b0;
      case (state)
        IDLE: if (pick_any) begin
          grant <= pick;
          owner <= pick_idx;
          len_q <= sel_len;
          cnt   <= '0;
`ifdef TX_SCHED_ROUND_ROBIN_EN
          last_owner <= pick_idx;
`endif
        end
        ARM: begin
          if (len_zero) begin
            done  <= grant;
            grant <= '0;
          end else if (is_armed) begin
            tx_symbol <= 1'b1;
            cnt       <= '0;
          end else if (arm_expired) begin
            done  <= grant;
            err   <= 1'b1;
            grant <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        WAIT_IQ: if (iq_valid) cnt <= CW'(len_q);
        PAYLOAD, TAIL: begin
          if (iq_lost) begin
            done      <= grant;
            err       <= 1'b1;
            grant     <= '0;
            tx_symbol <= 1'b1;
            cnt       <= '0;
          end else if (sym_event) begin
            if (state == PAYLOAD) begin
              tx_symbol <= sym_data[owner];
              sym_ready <= 1'b1;
              cnt       <= (cnt == ONE) ? '0 : cnt - 1'b1;
            end else begin
              tx_symbol <= 1'b1;
              if (cnt == TAIL_LAST) begin
                done  <= grant;
                grant <= '0;
                cnt   <= '0;
              end else begin
                cnt <= cnt + 1'b1;
              end
            end
          end
        end
        GUARD: if (sym_event) cnt <= (cnt == GUARD_LAST) ? '0 : cnt + 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_tx_burst_scheduler.sv
// tb/tb_tx_burst_scheduler.sv - directed self-checking bench for tx_burst_scheduler
module tb_tx_burst_scheduler;

  localparam int NUM_REQ  = 2;
  localparam int LEN_BITS = 8;

`ifdef TX_SCHED_ROUND_ROBIN_EN
  localparam logic [1:0] SECOND_GRANT = 2'b10;
`else
  localparam logic [1:0] SECOND_GRANT = 2'b01;
`endif

  logic                        clock = 1'b0;
  logic                        reset_n = 1'b0;
  logic [NUM_REQ-1:0]          req = '0;
  logic [NUM_REQ*LEN_BITS-1:0] req_len = '0;
  logic [NUM_REQ-1:0]          sym_data = '0;
  logic [NUM_REQ-1:0]          grant;
  logic                        sym_ready;
  logic [NUM_REQ-1:0]          done;
  logic                        err;
  logic                        busy;
  logic                        fire_burst;
  logic                        is_armed = 1'b0;
  logic                        symbol_input_strobe = 1'b0;
  logic                        iq_valid = 1'b0;
  logic                        tx_symbol;

  int checks = 0;
  int passed = 0;
  int fire_mon = 0;
  int done_mon = 0;

  logic [15:0]        obs_sym;
  int                 obs_ready;
  logic [NUM_REQ-1:0] obs_done;
  int                 obs_done_cnt;
  logic               obs_err;
  logic               obs_busy;

  always #5 clock = ~clock;

  tx_burst_scheduler dut (
    .clock               (clock),
    .reset_n             (reset_n),
    .req                 (req),
    .req_len             (req_len),
    .sym_data            (sym_data),
    .grant               (grant),
    .sym_ready           (sym_ready),
    .done                (done),
    .err                 (err),
    .busy                (busy),
    .fire_burst          (fire_burst),
    .is_armed            (is_armed),
    .symbol_input_strobe (symbol_input_strobe),
    .iq_valid            (iq_valid),
    .tx_symbol           (tx_symbol)
  );

  always @(negedge clock) begin
    if (fire_burst) fire_mon <= fire_mon + 1;
    if (done != '0) done_mon <= done_mon + 1;
  end

  // One symbol event per iteration: strobe high for two clocks, low for one.
  task automatic run_events(input int n, input logic [15:0] d0, input logic [15:0] d1);
    obs_sym = '0; obs_ready = 0; obs_done = '0; obs_done_cnt = 0; obs_err = 1'b0; obs_busy = 1'b0;
    for (int i = 0; i < n; i++) begin
      sym_data = {d1[i], d0[i]};
      symbol_input_strobe = 1'b1;
      for (int c = 0; c < 3; c++) begin
        @(negedge clock);
        if (c == 0) obs_sym[i] = tx_symbol;
        if (sym_ready) obs_ready++;
        if (done != '0) begin obs_done = obs_done | done; obs_done_cnt++; end
        if (err) obs_err = 1'b1;
        if (c == 1) symbol_input_strobe = 1'b0;
      end
      obs_busy = busy;
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (2) @(negedge clock);
    checks++; if (grant !== 2'b00 || done !== 2'b00) $display("FAIL reset_grant_done got=%b/%b want=00/00", grant, done); else passed++;
    checks++; if ({sym_ready, err, busy, fire_burst} !== 4'b0000) $display("FAIL reset_flags got=%b want=0000", {sym_ready, err, busy, fire_burst}); else passed++;
    checks++; if (tx_symbol !== 1'b1) $display("FAIL reset_tx_symbol got=%b want=1", tx_symbol); else passed++;
    reset_n = 1'b1;
    @(negedge clock);
    checks++; if (busy !== 1'b0 || grant !== 2'b00) $display("FAIL reset_idle got busy=%b grant=%b want 0/00", busy, grant); else passed++;
  endtask

  task automatic test_basic();
    int f0;
    f0 = fire_mon;
    req_len = {8'd0, 8'd4}; is_armed = 1'b1; iq_valid = 1'b0; req = 2'b01;
    @(negedge clock);
    checks++; if (grant !== 2'b01) $display("FAIL basic_grant got=%b want=01", grant); else passed++;
    checks++; if (busy !== 1'b1) $display("FAIL basic_busy got=%b want=1", busy); else passed++;
    checks++; if (fire_burst !== 1'b1) $display("FAIL basic_fire got=%b want=1", fire_burst); else passed++;
    @(negedge clock);
    checks++; if (fire_burst !== 1'b0 || tx_symbol !== 1'b1) $display("FAIL basic_wait_iq got fire=%b tx=%b want 0/1", fire_burst, tx_symbol); else passed++;
    iq_valid = 1'b1;
    @(negedge clock);
    run_events(4, 16'b1101, 16'b0010);
    checks++; if (obs_sym[3:0] !== 4'b1101) $display("FAIL basic_payload got=%b want=1101", obs_sym[3:0]); else passed++;
    checks++; if (obs_ready !== 4) $display("FAIL basic_sym_ready got=%0d want=4", obs_ready); else passed++;
    checks++; if (obs_done !== 2'b00) $display("FAIL basic_early_done got=%b want=00", obs_done); else passed++;
    run_events(3, 16'h0, 16'h0);
    checks++; if (obs_sym[2:0] !== 3'b111 || obs_ready !== 0) $display("FAIL basic_tail got sym=%b ready=%0d want 111/0", obs_sym[2:0], obs_ready); else passed++;
    checks++; if (obs_done !== 2'b01 || obs_done_cnt !== 1 || obs_err !== 1'b0) $display("FAIL basic_done got done=%b cnt=%0d err=%b want 01/1/0", obs_done, obs_done_cnt, obs_err); else passed++;
    req = 2'b00;
    checks++; if (grant !== 2'b00) $display("FAIL basic_grant_clear got=%b want=00", grant); else passed++;
    run_events(7, 16'h0, 16'h0);
    checks++; if (obs_busy !== 1'b1 || obs_sym[6:0] !== 7'h7f) $display("FAIL basic_guard got busy=%b sym=%b want 1/1111111", obs_busy, obs_sym[6:0]); else passed++;
    run_events(1, 16'h0, 16'h0);
    checks++; if (obs_busy !== 1'b0) $display("FAIL basic_idle got busy=%b want=0", obs_busy); else passed++;
    checks++; if (fire_mon - f0 !== 1) $display("FAIL basic_fire_count got=%0d want=1", fire_mon - f0); else passed++;
  endtask

  task automatic test_arbitration();
    int f0;
    f0 = fire_mon;
    req_len = {8'd2, 8'd2}; is_armed = 1'b1; iq_valid = 1'b1; req = 2'b11;
    @(negedge clock);
    checks++; if (grant !== 2'b01) $display("FAIL arb_first_grant got=%b want=01", grant); else passed++;
    repeat (2) @(negedge clock);
    run_events(2, 16'b01, 16'b10);
    checks++; if (obs_sym[1:0] !== 2'b01) $display("FAIL arb_first_syms got=%b want=01", obs_sym[1:0]); else passed++;
    run_events(3, 16'h0, 16'h0);
    checks++; if (obs_done !== 2'b01) $display("FAIL arb_first_done got=%b want=01", obs_done); else passed++;
    run_events(8, 16'h0, 16'h0);
    checks++; if (grant !== SECOND_GRANT) $display("FAIL arb_second_grant got=%b want=%b", grant, SECOND_GRANT); else passed++;
    @(negedge clock);
    run_events(2, 16'b01, 16'b10);
    checks++; if (obs_sym[1:0] !== SECOND_GRANT) $display("FAIL arb_second_syms got=%b want=%b", obs_sym[1:0], SECOND_GRANT); else passed++;
    run_events(3, 16'h0, 16'h0);
    checks++; if (obs_done !== SECOND_GRANT) $display("FAIL arb_second_done got=%b want=%b", obs_done, SECOND_GRANT); else passed++;
    req = 2'b00;
    run_events(8, 16'h0, 16'h0);
    checks++; if (obs_busy !== 1'b0) $display("FAIL arb_idle got busy=%b want=0", obs_busy); else passed++;
    checks++; if (fire_mon - f0 !== 2) $display("FAIL arb_fire_count got=%0d want=2", fire_mon - f0); else passed++;
  endtask

  task automatic test_timeout();
    int f0;
    int k;
    f0 = fire_mon;
    req_len = {8'd0, 8'd3}; is_armed = 1'b0; iq_valid = 1'b0; req = 2'b01;
    @(negedge clock);
    checks++; if (grant !== 2'b01) $display("FAIL timeout_grant got=%b want=01", grant); else passed++;
    k = 0;
    while (done == '0 && k < 1100) begin
      @(negedge clock);
      k++;
    end
    req = 2'b00;
    checks++; if (k !== 1023) $display("FAIL timeout_latency got=%0d want=1023", k); else passed++;
    checks++; if (done !== 2'b01 || err !== 1'b1 || grant !== 2'b00) $display("FAIL timeout_done got done=%b err=%b grant=%b want 01/1/00", done, err, grant); else passed++;
    @(negedge clock);
    checks++; if (busy !== 1'b0 || done !== 2'b00 || err !== 1'b0) $display("FAIL timeout_idle got busy=%b done=%b err=%b want 0/00/0", busy, done, err); else passed++;
    checks++; if (fire_mon - f0 !== 0) $display("FAIL timeout_no_fire got=%0d want=0", fire_mon - f0); else passed++;
  endtask

  task automatic test_abort();
    req_len = {8'd0, 8'd5}; is_armed = 1'b1; iq_valid = 1'b1; req = 2'b01;
    @(negedge clock);
    repeat (2) @(negedge clock);
    run_events(2, 16'b00, 16'b11);
    checks++; if (obs_ready !== 2 || obs_sym[1:0] !== 2'b00) $display("FAIL abort_payload got ready=%0d sym=%b want 2/00", obs_ready, obs_sym[1:0]); else passed++;
    iq_valid = 1'b0;
    @(negedge clock);
    checks++; if (done !== 2'b01 || err !== 1'b1 || grant !== 2'b00) $display("FAIL abort_done got done=%b err=%b grant=%b want 01/1/00", done, err, grant); else passed++;
    checks++; if (tx_symbol !== 1'b1) $display("FAIL abort_tx_symbol got=%b want=1", tx_symbol); else passed++;
    req = 2'b00;
    run_events(7, 16'h0, 16'h0);
    checks++; if (obs_busy !== 1'b1 || obs_ready !== 0 || obs_done !== 2'b00) $display("FAIL abort_guard got busy=%b ready=%0d done=%b want 1/0/00", obs_busy, obs_ready, obs_done); else passed++;
    run_events(1, 16'h0, 16'h0);
    checks++; if (obs_busy !== 1'b0) $display("FAIL abort_idle got busy=%b want=0", obs_busy); else passed++;
  endtask

  task automatic test_zero_len();
    int f0;
    f0 = fire_mon;
    req_len = {8'd7, 8'd0}; is_armed = 1'b1; iq_valid = 1'b1; req = 2'b01;
    @(negedge clock);
    checks++; if (grant !== 2'b01 || done !== 2'b00 || fire_burst !== 1'b0) $display("FAIL zero_grant got grant=%b done=%b fire=%b want 01/00/0", grant, done, fire_burst); else passed++;
    @(negedge clock);
    checks++; if (done !== 2'b01 || err !== 1'b0 || grant !== 2'b00) $display("FAIL zero_done got done=%b err=%b grant=%b want 01/0/00", done, err, grant); else passed++;
    req = 2'b00;
    @(negedge clock);
    checks++; if (busy !== 1'b0 || fire_mon - f0 !== 0) $display("FAIL zero_idle got busy=%b fires=%0d want 0/0", busy, fire_mon - f0); else passed++;
  endtask

  task automatic test_reset_mid_burst();
    int d0;
    req_len = {8'd0, 8'd4}; is_armed = 1'b1; iq_valid = 1'b1; req = 2'b01;
    @(negedge clock);
    repeat (2) @(negedge clock);
    run_events(1, 16'b0, 16'b1);
    checks++; if (obs_sym[0] !== 1'b0) $display("FAIL rst_pre_symbol got=%b want=0", obs_sym[0]); else passed++;
    d0 = done_mon;
    #2 reset_n = 1'b0;
    #1;
    checks++; if (grant !== 2'b00 || busy !== 1'b0 || tx_symbol !== 1'b1) $display("FAIL rst_async got grant=%b busy=%b tx=%b want 00/0/1", grant, busy, tx_symbol); else passed++;
    checks++; if ({sym_ready, done, err, fire_burst} !== 5'b0) $display("FAIL rst_async_pulses got=%b want=00000", {sym_ready, done, err, fire_burst}); else passed++;
    repeat (2) @(negedge clock);
    checks++; if (done_mon - d0 !== 0) $display("FAIL rst_no_done got=%0d want=0", done_mon - d0); else passed++;
    req_len = {8'd0, 8'd2};
    reset_n = 1'b1;
    @(negedge clock);
    checks++; if (grant !== 2'b01) $display("FAIL rst_regrant got=%b want=01", grant); else passed++;
    repeat (2) @(negedge clock);
    run_events(2, 16'b10, 16'b01);
    checks++; if (obs_sym[1:0] !== 2'b10 || obs_ready !== 2) $display("FAIL rst_payload got sym=%b ready=%0d want 10/2", obs_sym[1:0], obs_ready); else passed++;
    run_events(3, 16'h0, 16'h0);
    checks++; if (obs_done !== 2'b01 || obs_err !== 1'b0) $display("FAIL rst_done got done=%b err=%b want 01/0", obs_done, obs_err); else passed++;
    req = 2'b00;
    run_events(8, 16'h0, 16'h0);
    checks++; if (obs_busy !== 1'b0) $display("FAIL rst_idle got busy=%b want=0", obs_busy); else passed++;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_arbitration();
    test_timeout();
    test_abort();
    test_zero_len();
    test_reset_mid_burst();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout want=finish (passed %0d of %0d)", passed, checks);
    $fatal(1);
  end

endmodule
